mdbrot_iter_ctrl: RTL and testbench
===================================

# mdbrot_iter_ctrl

Per-pixel Mandelbrot iteration controller. It accepts one complex point c = (cr, ci), iterates z ← z² + c from z = 0, and reports the escape count. It time-shares a single internal `qmult` sign-magnitude fixed-point multiplier across the three products of each iteration (zr², zi², zr·zi). It sits between the pixel scanner, which supplies c and a start pulse, and the colour mapper, which consumes the iteration count.

## Interface

**Parameters**
- `Q`, 15: fractional bits; must match the `qmult` instance.
- `N`, 32: word width, sign-magnitude (bit N-1 is the sign, bits N-2:0 are the magnitude).
- `ITER_W`, 8: width of the iteration count.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `i_start`, in, 1: start request; sampled only in IDLE.
- `i_cr`, in, N: real part of c; captured when start is accepted.
- `i_ci`, in, N: imaginary part of c; captured when start is accepted.
- `i_max_iter`, in, ITER_W: iteration limit; captured when start is accepted.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_done`, out, 1: one-cycle pulse when the result is valid.
- `o_iter`, out, ITER_W: number of completed z updates; held until the next accepted start.
- `o_escaped`, out, 1: 1 if |z|² > 4.0 was detected; held with `o_iter`.

## Operation

**Number format and arithmetic**
- All values are N-bit sign-magnitude with Q fractional bits. 4.0 is represented as magnitude 4<<Q.
- Products come from one `qmult` instance. Its operands are muxed by state; its output is registered into `rr`, `ii` or `ri`.
- Signed add/subtract is done internally in sign-magnitude:
  - Equal signs: add the magnitudes, saturating at 2^(N-1)-1.
  - Unequal signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
  - A zero magnitude always gets sign 0 (no negative zero).
- Escape test: the unsigned sum of the `rr` and `ii` magnitudes is formed N bits wide (no wrap) and compared as > 4<<Q. Equality does not escape.
- 2·ri: magnitude shifted left 1 with saturation; sign kept.

**State machine**
- **IDLE**: if `i_start`, capture cr, ci and max_iter; set zr = zi = 0 and n = 0.
  - If max_iter == 0, go to DONE.
  - Otherwise go to MUL_RR.
- **MUL_RR**: rr ← zr·zr; go to MUL_II.
- **MUL_II**: ii ← zi·zi; go to MUL_RI.
- **MUL_RI**: ri ← zr·zi; go to UPDATE.
- **UPDATE**:
  - If |rr|+|ii| > 4.0: set escaped = 1 and go to DONE. z and n are unchanged.
  - Otherwise: zr ← rr − ii + cr; zi ← 2·ri + ci; n ← n+1.
  - If n+1 == max_iter, go to DONE; otherwise go to MUL_RR.
- **DONE**: `o_done` = 1, `o_iter` = n, `o_escaped` = escaped; go to IDLE.

**Boundary rules**
- `i_start` outside IDLE is ignored; there is no queueing.
- `i_cr`, `i_ci` and `i_max_iter` may change after acceptance without effect.
- `rst` asserted at any point returns the block to IDLE immediately. The run in progress is lost and no `o_done` is emitted.
- Reset values: `o_busy` = 0, `o_done` = 0, `o_iter` = 0, `o_escaped` = 0; all internal registers are 0.

## Timing

- Start is accepted in cycle T, the IDLE cycle with `i_start` = 1.
- Each iteration takes 4 cycles (MUL_RR, MUL_II, MUL_RI, UPDATE). The first runs in T+1..T+4.
- No escape, limit M ≥ 1: `o_done` is high in cycle T+4M+1; `o_iter` = M, `o_escaped` = 0.
- Escape detected after k updates: `o_done` is high in cycle T+4(k+1)+1; `o_iter` = k, `o_escaped` = 1.
- M = 0: `o_done` is high in cycle T+1; `o_iter` = 0, `o_escaped` = 0.
- `o_busy` is high from T+1 through the DONE cycle inclusive.
- The earliest next start is accepted at DONE+1.
- `o_iter` and `o_escaped` update in the DONE cycle and hold stable until the next DONE.

## Test plan

- c = (0, 0), max = 10, start at T → `o_done` at T+41; `o_iter` = 10, `o_escaped` = 0.
- c = (2.5, 0), max = 50 → z1 = 2.5, then rr = 6.25 escapes; `o_iter` = 1, `o_escaped` = 1, `o_done` at T+9.
- c = (−2.0, 0), max = 5 → z stays at 2.0 with rr = 4.0 exactly, which must not escape; exercises sign-magnitude subtract. Expect `o_iter` = 5, `o_escaped` = 0.
- c = (0, 1.0), max = 8 → orbit i, −1+i, −i, −1+i, … never escapes; no negative-zero sign bit appears in zr. Expect `o_iter` = 8, `o_escaped` = 0.
- max = 0 → `o_done` at T+1 with `o_iter` = 0. Also: `i_start` pulsed while busy is ignored, and the result is unchanged.
- c = (2.5, 0), `rst` pulsed at T+3 → all outputs 0, no `o_done`. A new start at IDLE then completes normally with `o_iter` = 1.

Source files
------------

// File: rtl/mdbrot_iter_ctrl_if.sv
// Scanner <-> iteration controller bundle.
//   master (pixel scanner / bench): drives i_start, i_cr, i_ci, i_max_iter
//   slave  (mdbrot_iter_ctrl)     : drives o_busy, o_done, o_iter, o_escaped
// Complex values are N-bit sign-magnitude (bit N-1 sign).
interface mdbrot_iter_ctrl_if #(
  parameter int N      = 32,
  parameter int ITER_W = 8
);
  logic              i_start;
  logic [N-1:0]      i_cr;
  logic [N-1:0]      i_ci;
  logic [ITER_W-1:0] i_max_iter;
  logic              o_busy;
  logic              o_done;
  logic [ITER_W-1:0] o_iter;
  logic              o_escaped;

  modport master (
    output i_start, i_cr, i_ci, i_max_iter,
    input  o_busy, o_done, o_iter, o_escaped
  );

  modport slave (
    input  i_start, i_cr, i_ci, i_max_iter,
    output o_busy, o_done, o_iter, o_escaped
  );
endinterface

// File: rtl/mdbrot_iter_ctrl.sv
// Per-pixel Mandelbrot iteration controller.
// Iterates z <- z^2 + c from z = 0 for one point c and reports how many
// z updates completed before |z|^2 > 4.0 or the iteration limit.
// One shared qmult produces zr*zr, zi*zi and zr*zi on successive cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mdbrot_iter_ctrl_if.slave (start/c/limit in, busy/done/result out)
module mdbrot_iter_ctrl #(
  parameter int Q      = 15,
  parameter int N      = 32,
  parameter int ITER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  mdbrot_iter_ctrl_if.slave   bus
);

  localparam logic [N-2:0] MAG_MAX = '1;
  // 4.0 in Q format, N bits wide so the rr+ii magnitude sum never wraps
  localparam logic [N-1:0] FOUR    = {{(N-3){1'b0}}, 3'b100} << Q;

  typedef enum logic [2:0] {
    IDLE, MUL_RR, MUL_II, MUL_RI, UPDATE, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      cr_q, cr_d, ci_q, ci_d;
  logic [N-1:0]      zr_q, zr_d, zi_q, zi_d;
  logic [N-1:0]      rr_q, rr_d, ii_q, ii_d, ri_q, ri_d;
  logic [ITER_W-1:0] max_q, max_d, n_q, n_d;
  logic              esc_q, esc_d;
  logic [ITER_W-1:0] res_iter_q, res_iter_d;
  logic              res_esc_q, res_esc_d;

  logic [N-1:0]      mul_a, mul_b, prod;
  logic [N-1:0]      mag_sum;
  logic              escape;

  // Sign-magnitude add; equal signs saturate, zero is always positive.
  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sgn;
    sum = '0;
    if (a[N-1] == b[N-1]) begin
      sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
      mag = sum[N-1] ? MAG_MAX : sum[N-2:0];
      sgn = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      mag = a[N-2:0] - b[N-2:0];
      sgn = a[N-1];
    end else begin
      mag = b[N-2:0] - a[N-2:0];
      sgn = b[N-1];
    end
    if (mag == '0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  function automatic logic [N-1:0] sm_neg(input logic [N-1:0] a);
    return {a[N-1] ^ (|a[N-2:0]), a[N-2:0]};
  endfunction

  // 2*a with magnitude saturation, sign kept
  function automatic logic [N-1:0] sm_dbl(input logic [N-1:0] a);
    return {a[N-1], a[N-2] ? MAG_MAX : {a[N-3:0], 1'b0}};
  endfunction

  qmult #(.Q(Q), .N(N)) u_qmult (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  assign mag_sum = {1'b0, rr_q[N-2:0]} + {1'b0, ii_q[N-2:0]};
  assign escape  = mag_sum > FOUR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cr_q       <= '0;
      ci_q       <= '0;
      zr_q       <= '0;
      zi_q       <= '0;
      rr_q       <= '0;
      ii_q       <= '0;
      ri_q       <= '0;
      max_q      <= '0;
      n_q        <= '0;
      esc_q      <= 1'b0;
      res_iter_q <= '0;
      res_esc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cr_q       <= cr_d;
      ci_q       <= ci_d;
      zr_q       <= zr_d;
      zi_q       <= zi_d;
      rr_q       <= rr_d;
      ii_q       <= ii_d;
      ri_q       <= ri_d;
      max_q      <= max_d;
      n_q        <= n_d;
      esc_q      <= esc_d;
      res_iter_q <= res_iter_d;
      res_esc_q  <= res_esc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cr_d       = cr_q;
    ci_d       = ci_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    rr_d       = rr_q;
    ii_d       = ii_q;
    ri_d       = ri_q;
    max_d      = max_q;
    n_d        = n_q;
    esc_d      = esc_q;
    res_iter_d = res_iter_q;
    res_esc_d  = res_esc_q;
    mul_a      = zr_q;
    mul_b      = zr_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          cr_d    = bus.i_cr;
          ci_d    = bus.i_ci;
          max_d   = bus.i_max_iter;
          zr_d    = '0;
          zi_d    = '0;
          n_d     = '0;
          esc_d   = 1'b0;
          state_d = (bus.i_max_iter == '0) ? DONE : MUL_RR;
        end
      end
      MUL_RR: begin
        rr_d    = prod;
        state_d = MUL_II;
      end
      MUL_II: begin
        mul_a   = zi_q;
        mul_b   = zi_q;
        ii_d    = prod;
        state_d = MUL_RI;
      end
      MUL_RI: begin
        mul_b   = zi_q;
        ri_d    = prod;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (escape) begin
          esc_d   = 1'b1;
          state_d = DONE;
        end else begin
          zr_d    = sm_add(sm_add(rr_q, sm_neg(ii_q)), cr_q);
          zi_d    = sm_add(sm_dbl(ri_q), ci_q);
          n_d     = n_q + 1'b1;
          state_d = (n_d == max_q) ? DONE : MUL_RR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Result registers load on entry to DONE so they are visible during
    // the o_done cycle and stay put until the next run finishes.
    if (state_d == DONE && state_q != DONE) begin
      res_iter_d = n_d;
      res_esc_d  = esc_d;
    end
  end

  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_done    = (state_q == DONE);
  assign bus.o_iter    = res_iter_q;
  assign bus.o_escaped = res_esc_q;

endmodule

// Sign-magnitude Q-format multiplier (combinational).
//   a_i, b_i : N-bit sign-magnitude operands, Q fractional bits
//   p_o      : product, magnitude truncated toward zero, saturated on overflow
module qmult #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);
  localparam int MW = N - 1;

  logic [2*MW-1:0] full, shifted;
  logic [MW-1:0]   mag;

  assign full    = {{MW{1'b0}}, a_i[MW-1:0]} * {{MW{1'b0}}, b_i[MW-1:0]};
  assign shifted = full >> Q;
  assign mag     = (|shifted[2*MW-1:MW]) ? '1 : shifted[MW-1:0];
  assign p_o     = {(a_i[N-1] ^ b_i[N-1]) & (|mag), mag};
endmodule

// File: tb/tb_mdbrot_iter_ctrl.sv
module tb_mdbrot_iter_ctrl;
  localparam int Q = 15;
  localparam int N = 32;
  localparam int W = 8;
  localparam longint SMAX = (64'sd1 <<< (N-1)) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdbrot_iter_ctrl_if #(.N(N), .ITER_W(W)) bus();

  mdbrot_iter_ctrl #(.Q(Q), .N(N), .ITER_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int iter;
    int esc;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   prev_it = 0;
  int   prev_esc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain signed arithmetic) ----------------
  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < -SMAX) return -SMAX;
    return v;
  endfunction

  // product truncated toward zero
  function automatic longint qm(input longint a, input longint b);
    longint p;
    p = a * b;
    if (p >= 0) return sat(p >>> Q);
    return -sat((-p) >>> Q);
  endfunction

  task automatic model(input longint cr, input longint ci, input int mx,
                       output int it, output int esc);
    longint zr, zi, rr, ii, ri, nzr;
    zr = 0; zi = 0; it = 0; esc = 0;
    while (it < mx) begin
      rr = qm(zr, zr);
      ii = qm(zi, zi);
      ri = qm(zr, zi);
      if (rr + ii > (64'sd4 <<< Q)) begin
        esc = 1;
        break;
      end
      nzr = sat(sat(rr - ii) + cr);
      zi  = sat(sat(2 * ri) + ci);
      zr  = nzr;
      it++;
    end
  endtask

  function automatic logic [N-1:0] to_sm(input longint v);
    logic [N-1:0] r;
    longint m;
    m = (v < 0) ? -v : v;
    r = m[N-1:0];
    r[N-1] = (v < 0);
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_run(input longint cr, input longint ci, input int mx, input bit push);
    int w, it, esc, lat;
    exp_t e;
    w = 0;
    while (bus.o_busy && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (bus.o_busy) chk("idle_wait_timeout", 1, 0);
    bus.i_cr       = to_sm(cr);
    bus.i_ci       = to_sm(ci);
    bus.i_max_iter = mx[W-1:0];
    bus.i_start    = 1'b1;
    model(cr, ci, mx, it, esc);
    lat = (esc != 0) ? 4 * (it + 1) + 1 : ((mx == 0) ? 1 : 4 * mx + 1);
    if (push) begin
      e.iter = it; e.esc = esc; e.cyc = cyc + lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.i_start    = 1'b0;
    // inputs change after acceptance; must have no effect
    bus.i_cr       = $urandom;
    bus.i_ci       = $urandom;
    bus.i_max_iter = W'($urandom);
    chk("busy_after_start", bus.o_busy, 1);
    if (mx != 0) begin
      chk("iter_held", bus.o_iter, prev_it);
      chk("esc_held", bus.o_escaped, prev_esc);
    end
    if (push) begin
      prev_it  = it;
      prev_esc = esc;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_cr       = '0;
    bus.i_ci       = '0;
    bus.i_max_iter = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_iter", bus.o_iter, 0);
    chk("rst_esc", bus.o_escaped, 0);
    rst = 1'b0;
    @(negedge clk);

    // monitor: pops the scoreboard whenever the DUT reports a result
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && bus.o_done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("iter", bus.o_iter, e.iter);
            chk("escaped", bus.o_escaped, e.esc);
            chk("done_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    // directed points (values in Q15)
    start_run(0, 0, 10, 1);          drain();
    start_run(81920, 0, 50, 1);      drain();   // 2.5: escapes after 1
    start_run(-65536, 0, 5, 1);      drain();   // -2.0: rr == 4.0 exactly
    start_run(0, 32768, 8, 1);       drain();   // i: periodic orbit
    start_run(0, 0, 0, 1);           drain();   // zero limit

    // start pulse while busy must be ignored
    start_run(0, 0, 10, 1);
    repeat (4) @(negedge clk);
    bus.i_cr = to_sm(81920); bus.i_ci = '0; bus.i_max_iter = 8'd1;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();

    // reset in the middle of a run: no done, outputs cleared
    start_run(81920, 0, 50, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_done", bus.o_done, 0);
    chk("midrst_iter", bus.o_iter, 0);
    chk("midrst_esc", bus.o_escaped, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_it = 0; prev_esc = 0;
    repeat (15) @(negedge clk);
    start_run(81920, 0, 50, 1);      drain();

    // randomized points, back to back
    repeat (25) begin
      longint cr, ci;
      int mx;
      cr = longint'($urandom_range(0, 163840)) - 81920;
      ci = longint'($urandom_range(0, 163840)) - 81920;
      mx = $urandom_range(0, 30);
      start_run(cr, ci, mx, 1);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
